// File: rtl/ro_race_comparator_pkg.sv
// Shared constants and types for the ring-oscillator race comparator.
package ro_race_comparator_pkg;

    localparam int NUM_RO = 16;
    localparam int SEL_W  = $clog2(NUM_RO);
    localparam int CHAL_W = 2 * SEL_W;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } race_state_t;

    typedef logic [SEL_W-1:0] ro_sel_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_race_comparator_if.sv
// Challenge/response bundle between the scrambler side and the race comparator.
interface ro_race_comparator_if #(
    parameter int CNT_W = 16
);
    import ro_race_comparator_pkg::*;

    logic                  start;
    logic [CHAL_W-1:0]     challenge;
    logic [NUM_RO-1:0]     ro_sync;
    logic                  busy;
    logic                  done;
    logic                  increment;
    logic                  response;
    logic                  tie;
    logic [CNT_W-1:0]      count_a;
    logic [CNT_W-1:0]      count_b;

    modport master (
        output start, challenge, ro_sync,
        input  busy, done, increment, response, tie, count_a, count_b
    );

    modport slave (
        input  start, challenge, ro_sync,
        output busy, done, increment, response, tie, count_a, count_b
    );

endinterface

// File: rtl/ro_race_comparator_edge_counter.sv
// Rising-edge counter for one selected RO; saturates at all-ones instead of wrapping.
module ro_race_comparator_edge_counter #(
    parameter int CNT_W = 16
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_ro_bit,
    output logic [CNT_W-1:0] o_count
);

    logic             r_hist;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;
    logic             w_sat;

    assign w_rise  = i_ro_bit & ~r_hist;
    assign w_sat   = &r_count;
    assign o_count = r_count;

    // History always follows the input so the first enabled cycle sees a true previous value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist  <= 1'b0;
            r_count <= '0;
        end else begin
            r_hist <= i_ro_bit;
            if (i_clear)
                r_count <= '0;
            else if (i_enable && w_rise && !w_sat)
                r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ro_race_comparator.sv
// Races two challenge-selected ring oscillators over a fixed window and emits one response bit.
// state   | meaning
// IDLE    | waiting for start, previous result held
// SETTLE  | mux/edge history settling, counters cleared
// COUNT   | counting rising edges of RO A and RO B
// COMPARE | register response/tie/counts
// DONE    | done/increment pulse
module ro_race_comparator
    import ro_race_comparator_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW_CYCLES = 4096
)(
    input logic                 i_clk,
    input logic                 i_rst,
    ro_race_comparator_if.slave io_bus
);

    localparam int PH_W = $clog2(max_int(SETTLE_CYCLES, WINDOW_CYCLES)) + 1;
    typedef logic [PH_W-1:0] phase_t;
    localparam phase_t SETTLE_LOAD = phase_t'(SETTLE_CYCLES - 1);
    localparam phase_t WINDOW_LOAD = phase_t'(WINDOW_CYCLES - 1);

    race_state_t      r_state;
    phase_t           r_phase;
    ro_sel_t          r_sel_a;
    ro_sel_t          r_sel_b;
    logic             r_busy;
    logic             r_done;
    logic             r_inc;
    logic             r_response;
    logic             r_tie;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;

    logic             w_ro_a;
    logic             w_ro_b;
    logic             w_clear;
    logic             w_enable;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;

    assign w_ro_a   = io_bus.ro_sync[r_sel_a];
    assign w_ro_b   = io_bus.ro_sync[r_sel_b];
    assign w_clear  = (r_state == SETTLE);
    assign w_enable = (r_state == COUNT);

    ro_race_comparator_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .i_ro_bit (w_ro_a),
        .o_count  (w_cnt_a)
    );

    ro_race_comparator_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .i_ro_bit (w_ro_b),
        .o_count  (w_cnt_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inc      <= 1'b0;
            r_response <= 1'b0;
            r_tie      <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
        end else begin
            r_done <= 1'b0;
            r_inc  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_sel_a <= io_bus.challenge[CHAL_W-1:SEL_W];
                        r_sel_b <= io_bus.challenge[SEL_W-1:0];
                        r_phase <= SETTLE_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_phase == '0) begin
                        r_phase <= WINDOW_LOAD;
                        r_state <= COUNT;
                    end else begin
                        r_phase <= r_phase - phase_t'(1);
                    end
                end
                COUNT: begin
                    if (r_phase == '0)
                        r_state <= COMPARE;
                    else
                        r_phase <= r_phase - phase_t'(1);
                end
                COMPARE: begin
                    r_response <= (w_cnt_a > w_cnt_b);
                    r_tie      <= (w_cnt_a == w_cnt_b);
                    r_count_a  <= w_cnt_a;
                    r_count_b  <= w_cnt_b;
                    r_done     <= 1'b1;
                    r_inc      <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.increment = r_inc;
    assign io_bus.response  = r_response;
    assign io_bus.tie       = r_tie;
    assign io_bus.count_a   = r_count_a;
    assign io_bus.count_b   = r_count_b;

endmodule
